// File: rtl/kpt_stream_out_if.sv
// Framed 16-bit keypoint word stream with valid/ready handshake.
interface kpt_stream_out_if;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/kpt_stream_out.sv
// Drains the layer 1 / layer 2 keypoint memories onto a framed word stream:
// header per layer, then a row word and a col word per entry.
module kpt_stream_out #(
  parameter int MAX_KPT = 2000,
  parameter int ADDR_W  = 11,
  parameter int ROW_W   = 9,
  parameter int COL_W   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        kpt1_count,
  input  logic [ADDR_W-1:0]        kpt2_count,
  output logic                     rd_en,
  output logic                     rd_layer,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [ROW_W+COL_W-1:0]   rd_data,
  kpt_stream_out_if.master         strm,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {IDLE, HDR, RD, WT, ROW, COL, FIN} state_t;

  localparam logic [ADDR_W-1:0] MAX_C = ADDR_W'(MAX_KPT);

  function automatic logic [ADDR_W-1:0] clamp(input logic [ADDR_W-1:0] c);
    return (c > MAX_C) ? MAX_C : c;
  endfunction

  function automatic logic [15:0] hdr_word(input logic l, input logic [ADDR_W-1:0] c);
    return 16'({3'b101, l, 1'b0, c});
  endfunction

  state_t              state_q, state_d;
  logic                layer_q, layer_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                out_valid_q, out_valid_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                rd_en_q, rd_en_d, rd_layer_q, rd_layer_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d, done_q, done_d;

  logic [ADDR_W-1:0]   cur_cnt;
  logic                accept, next_layer;

  assign cur_cnt = layer_q ? cnt2_q : cnt1_q;
  assign accept  = out_valid_q && strm.out_ready;

  // Outputs are computed for the next state so they leave straight from flops.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    idx_d       = idx_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_en_d     = 1'b0;
    rd_layer_d  = rd_layer_q;
    rd_addr_d   = rd_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    next_layer  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d     = HDR;
        layer_d     = 1'b0;
        idx_d       = '0;
        cnt1_d      = clamp(kpt1_count);
        cnt2_d      = clamp(kpt2_count);
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = hdr_word(1'b0, clamp(kpt1_count));
      end
      HDR: if (accept) begin
        if (cur_cnt == '0) next_layer = 1'b1;
        else begin
          state_d     = RD;
          out_valid_d = 1'b0;
          rd_en_d     = 1'b1;
          rd_addr_d   = idx_q;
          rd_layer_d  = layer_q;
        end
      end
      RD: state_d = WT;
      WT: begin
        state_d     = ROW;
        col_d       = rd_data[COL_W-1:0];
        out_valid_d = 1'b1;
        out_data_d  = 16'(rd_data[ROW_W+COL_W-1:COL_W]);
      end
      ROW: if (accept) begin
        state_d    = COL;
        out_data_d = 16'(col_q);
      end
      COL: if (accept) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == cur_cnt - 1'b1) next_layer = 1'b1;
        else begin
          state_d     = RD;
          out_valid_d = 1'b0;
          rd_en_d     = 1'b1;
          rd_addr_d   = idx_q + 1'b1;
          rd_layer_d  = layer_q;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (next_layer) begin
      idx_d = '0;
      if (!layer_q) begin
        state_d     = HDR;
        layer_d     = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = hdr_word(1'b1, cnt2_q);
      end else begin
        state_d     = FIN;
        out_valid_d = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      layer_q     <= 1'b0;
      idx_q       <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_layer_q  <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      idx_q       <= idx_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_en_q     <= rd_en_d;
      rd_layer_q  <= rd_layer_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign rd_en          = rd_en_q;
  assign rd_layer       = rd_layer_q;
  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_kpt_stream_out.sv
// Directed vector bench for kpt_stream_out: framing, backpressure, clamping,
// mid-stream reset and start-while-busy.
module tb_kpt_stream_out;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [10:0] k1 = '0, k2 = '0;
  logic        rd_en, rd_layer, busy, done;
  logic [10:0] rd_addr;
  logic [18:0] rd_data = '0;

  kpt_stream_out_if strm();

  kpt_stream_out dut (
    .clk(clk), .rst(rst), .start(start), .kpt1_count(k1), .kpt2_count(k2),
    .rd_en(rd_en), .rd_layer(rd_layer), .rd_addr(rd_addr), .rd_data(rd_data),
    .strm(strm), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, data valid the cycle after rd_en.
  logic [18:0] mem1 [2048];
  logic [18:0] mem2 [2048];
  always @(posedge clk) if (rd_en) rd_data <= rd_layer ? mem2[rd_addr] : mem1[rd_addr];

  // Ready: level, or the 1,0,0,1 repeating pattern.
  bit tog = 1'b0, rdy_lvl = 1'b1;
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;
  assign strm.out_ready = tog ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : rdy_lvl;

  // Monitor: accepted words, done pulses, reads, stall-stability violations.
  logic [15:0] got[$];
  int          n_done = 0, n_rd = 0, n_viol = 0, max_addr = 0;
  logic [10:0] last_addr = '0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  always @(posedge clk) begin
    if (!rst && strm.out_valid && strm.out_ready) got.push_back(strm.out_data);
    if (done) n_done++;
    if (rd_en) begin
      n_rd++;
      last_addr = rd_addr;
      if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
    end
    if (prev_stall && !rst && (!strm.out_valid || strm.out_data !== prev_data)) n_viol++;
    prev_stall = !rst && strm.out_valid && !strm.out_ready;
    prev_data  = strm.out_data;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] ent(input int r, input int c);
    logic [18:0] e;
    e = {r[8:0], c[9:0]};
    return e;
  endfunction

  typedef struct {
    int               n1, n2;
    bit               tog;
    int               poke;     // lat at which a stray start is pulsed (0 = none)
    int               exp_lat;  // edges from start to done visible (-1 = unchecked)
    int               n_words;
    int               n_rd;
    logic [15:0][15:0] w;
    logic [3:0][18:0]  e1;
    logic [3:0][18:0]  e2;
  } vec_t;

  vec_t vt [5];

  task automatic run_vec(input vec_t v, input string nm);
    int b_w, b_d, b_r, b_v, lat;
    bit seen;
    logic [15:0] a;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin mem1[k] = v.e1[k]; mem2[k] = v.e2[k]; end
    tog = v.tog; k1 = 11'(v.n1); k2 = 11'(v.n2);
    b_w = got.size(); b_d = n_done; b_r = n_rd; b_v = n_viol;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, " hdr_valid"}, strm.out_valid, 1);
    chk({nm, " hdr_data"}, strm.out_data, v.w[0]);
    chk({nm, " busy"}, busy, 1);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (lat == v.poke) begin start = 1'b1; k1 = 11'd7; end
      else start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({nm, " done_seen"}, seen, 1);
    if (v.exp_lat >= 0) chk({nm, " latency"}, lat, v.exp_lat);
    chk({nm, " n_words"}, got.size() - b_w, v.n_words);
    for (int k = 0; k < v.n_words; k++) begin
      a = (b_w + k < got.size()) ? got[b_w + k] : 16'hxxxx;
      chk($sformatf("%s word%0d", nm, k), a, v.w[k]);
    end
    chk({nm, " n_rd"}, n_rd - b_r, v.n_rd);
    chk({nm, " stall_stable"}, n_viol - b_v, 0);
    @(posedge clk); #1;
    chk({nm, " done_pulses"}, n_done - b_d, 1);
    chk({nm, " idle_after"}, {done, busy, strm.out_valid}, 0);
    tog = 1'b0;
  endtask

  initial begin
    int b_w, b_r, lat;
    bit seen;
    logic [15:0] a;

    vt[0].n1 = 2; vt[0].n2 = 1; vt[0].tog = 0; vt[0].poke = 0; vt[0].exp_lat = 14;
    vt[0].n_words = 8; vt[0].n_rd = 3;
    vt[0].e1[0] = ent(5, 7); vt[0].e1[1] = ent(479, 639); vt[0].e2[0] = ent(0, 0);
    vt[0].w[0] = 16'hA002; vt[0].w[1] = 16'h0005; vt[0].w[2] = 16'h0007; vt[0].w[3] = 16'h01DF;
    vt[0].w[4] = 16'h027F; vt[0].w[5] = 16'hB001; vt[0].w[6] = 16'h0000; vt[0].w[7] = 16'h0000;

    vt[1] = vt[0];
    vt[1].n1 = 0; vt[1].n2 = 0; vt[1].exp_lat = 2; vt[1].n_words = 2; vt[1].n_rd = 0;
    vt[1].w[0] = 16'hA000; vt[1].w[1] = 16'hB000;

    vt[2] = vt[0]; vt[2].tog = 1; vt[2].exp_lat = -1;

    vt[3].n1 = 1; vt[3].n2 = 3; vt[3].tog = 0; vt[3].poke = 0; vt[3].exp_lat = 18;
    vt[3].n_words = 10; vt[3].n_rd = 4;
    vt[3].e1[0] = ent(300, 1023);
    vt[3].e2[0] = ent(1, 2); vt[3].e2[1] = ent(511, 0); vt[3].e2[2] = ent(2, 3);
    vt[3].w[0] = 16'hA001; vt[3].w[1] = 16'h012C; vt[3].w[2] = 16'h03FF; vt[3].w[3] = 16'hB003;
    vt[3].w[4] = 16'h0001; vt[3].w[5] = 16'h0002; vt[3].w[6] = 16'h01FF; vt[3].w[7] = 16'h0000;
    vt[3].w[8] = 16'h0002; vt[3].w[9] = 16'h0003;

    vt[4] = vt[0]; vt[4].poke = 5;

    // Reset held with start high: reset wins, outputs at reset values.
    start = 1'b1; k1 = 11'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {strm.out_valid, strm.out_data, rd_en, rd_addr, rd_layer, busy, done}, 0);
    @(negedge clk); start = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Clamp: count 2047 becomes 2000, 4000 data words, last read at 1999.
    @(negedge clk);
    for (int i = 0; i < 2000; i++) mem1[i] = {i[8:0], i[9:0]};
    k1 = 11'd2047; k2 = 11'd0;
    b_w = got.size(); b_r = n_rd;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("clamp hdr", strm.out_data, 16'hA7D0);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 9000) begin
      @(posedge clk); #1; lat++;
      if (done) seen = 1'b1;
    end
    chk("clamp done_seen", seen, 1);
    chk("clamp n_words", got.size() - b_w, 4002);
    chk("clamp n_rd", n_rd - b_r, 2000);
    chk("clamp last_addr", last_addr, 11'd1999);
    chk("clamp max_addr", max_addr, 1999);
    a = (b_w + 3999 < got.size()) ? got[b_w + 3999] : 16'hxxxx;
    chk("clamp last_row", a, 16'h01CF);
    a = (b_w + 4000 < got.size()) ? got[b_w + 4000] : 16'hxxxx;
    chk("clamp last_col", a, 16'h03CF);
    a = (b_w + 4001 < got.size()) ? got[b_w + 4001] : 16'hxxxx;
    chk("clamp hdr2", a, 16'hB000);

    // Reset in the middle of layer 1, then a fresh frame.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) mem1[k] = ent(k + 1, k + 2);
    k1 = 11'd3; k2 = 11'd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst quiet", {strm.out_valid, busy, rd_en, done}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    b_w = got.size();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("midrst new_hdr", {strm.out_valid, strm.out_data}, {1'b1, 16'hA003});
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1; lat++;
      if (done) seen = 1'b1;
    end
    chk("midrst done_seen", seen, 1);
    chk("midrst n_words", got.size() - b_w, 8);
    a = (b_w + 5 < got.size()) ? got[b_w + 5] : 16'hxxxx;
    chk("midrst row3", a, 16'h0003);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
